// File: rtl/mem_loader_if.sv
// rtl/mem_loader_if.sv - byte-serial load stream interface for mem_loader
//
// Purpose: groups the valid/ready byte stream that feeds mem_loader.
// Signals:
//    rx_valid  source offers a byte on rx_data
//    rx_data   8-bit load byte
//    rx_ready  sink accepts; transfer when rx_valid && rx_ready at a rising edge
// Modports:
//    master  byte source (drives rx_valid/rx_data)
//    slave   byte sink   (drives rx_ready), used by mem_loader
interface mem_loader_if;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       rx_ready;

   modport master (output rx_valid, output rx_data, input rx_ready);
   modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - byte-serial loader for instruction and data memories
//
// Purpose: assembles little-endian 32-bit words from a byte stream, writes
// DEPTH words to instruction memory then DEPTH words to data memory, holds the
// core in reset during the load, then releases it after a 2-cycle settle.
// Optional build macro MEM_LOADER_CHECKSUM_EN adds a running XOR over all
// payload bytes and one trailing checksum byte that must match it.
// Ports:
//    clk          only clock, rising edge
//    rst          synchronous active-high reset
//    rx           mem_loader_if.slave byte stream (rx_valid/rx_data/rx_ready)
//    instr_we     instruction-memory write strobe (one cycle per word)
//    instr_waddr  instruction-memory word address
//    instr_wdata  instruction-memory write word
//    data_we      data-memory write strobe (one cycle per word)
//    data_waddr   data-memory word address
//    data_wdata   data-memory write word
//    core_rst_n   active-low core reset, 1 only in RUN
//    done         load complete, core running
//    err          checksum mismatch (always 0 without the macro)
module mem_loader #(
   parameter int DEPTH = 32,
   parameter int WIDTH = 32,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   mem_loader_if.slave      rx,
   output logic             instr_we,
   output logic [AW-1:0]    instr_waddr,
   output logic [WIDTH-1:0] instr_wdata,
   output logic             data_we,
   output logic [AW-1:0]    data_waddr,
   output logic [WIDTH-1:0] data_wdata,
   output logic             core_rst_n,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      LOAD_I,
      LOAD_D,
`ifdef MEM_LOADER_CHECKSUM_EN
      CHECK,
`endif
      RELEASE,
      RUN,
      ERROR
   } state_t;

   state_t        state;
   logic [1:0]    bcnt;
   logic [AW-1:0] wcnt;
   logic [23:0]   asm_buf;
   logic          rel_cnt;
   logic          ready;
   logic          accept;
   logic [31:0]   word;
   logic          last_word;

`ifdef MEM_LOADER_CHECKSUM_EN
   logic [7:0]    csum;
   logic          err_q;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_comb begin
      ready = 1'b0;
      case (state)
         LOAD_I, LOAD_D: ready = 1'b1;
`ifdef MEM_LOADER_CHECKSUM_EN
         CHECK:          ready = 1'b1;
`endif
         default:        ready = 1'b0;
      endcase
   end

   assign rx.rx_ready = ready;
   assign accept      = ready & rx.rx_valid;
   // The 4th byte goes straight into the top lane, so the word is written on
   // the accepting edge with no extra assembly cycle.
   assign word        = {rx.rx_data, asm_buf};
   assign last_word   = (wcnt == AW'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= LOAD_I;
         bcnt        <= 2'd0;
         wcnt        <= '0;
         asm_buf     <= '0;
         rel_cnt     <= 1'b0;
         instr_we    <= 1'b0;
         instr_waddr <= '0;
         instr_wdata <= '0;
         data_we     <= 1'b0;
         data_waddr  <= '0;
         data_wdata  <= '0;
         core_rst_n  <= 1'b0;
         done        <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
         csum        <= 8'd0;
         err_q       <= 1'b0;
`endif
      end else begin
         instr_we <= 1'b0;
         data_we  <= 1'b0;
         case (state)
            LOAD_I, LOAD_D: begin
               if (accept) begin
                  bcnt <= bcnt + 2'd1;
`ifdef MEM_LOADER_CHECKSUM_EN
                  csum <= csum ^ rx.rx_data;
`endif
                  case (bcnt)
                     2'd0: asm_buf[7:0]   <= rx.rx_data;
                     2'd1: asm_buf[15:8]  <= rx.rx_data;
                     2'd2: asm_buf[23:16] <= rx.rx_data;
                     default: begin
                        if (state == LOAD_I) begin
                           instr_we    <= 1'b1;
                           instr_waddr <= wcnt;
                           instr_wdata <= WIDTH'(word);
                        end else begin
                           data_we     <= 1'b1;
                           data_waddr  <= wcnt;
                           data_wdata  <= WIDTH'(word);
                        end
                        if (last_word) begin
                           wcnt <= '0;
                           if (state == LOAD_I) begin
                              state <= LOAD_D;
                           end else begin
`ifdef MEM_LOADER_CHECKSUM_EN
                              state <= CHECK;
`else
                              state <= RELEASE;
`endif
                           end
                        end else begin
                           wcnt <= wcnt + AW'(1);
                        end
                     end
                  endcase
               end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            CHECK: begin
               if (accept) begin
                  if (rx.rx_data == csum) begin
                     state <= RELEASE;
                  end else begin
                     state <= ERROR;
                     err_q <= 1'b1;
                  end
               end
            end
`endif
            // Two cycles in RELEASE: rel_cnt is 0 on entry, 1 on the second.
            RELEASE: begin
               if (rel_cnt) begin
                  state      <= RUN;
                  core_rst_n <= 1'b1;
                  done       <= 1'b1;
               end else begin
                  rel_cnt <= 1'b1;
               end
            end
            default: ;  // RUN and ERROR hold until rst
         endcase
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader
module tb_mem_loader;
   localparam int DEPTH  = 32;
   localparam int WIDTH  = 32;
   localparam int AW     = $clog2(DEPTH);
   localparam int NBYTES = 8 * DEPTH;

   logic             clk = 1'b0;
   logic             rst;
   logic             instr_we, data_we, core_rst_n, done, err;
   logic [AW-1:0]    instr_waddr, data_waddr;
   logic [WIDTH-1:0] instr_wdata, data_wdata;

   always #5 clk = ~clk;

   mem_loader_if rx_if ();

   mem_loader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx          (rx_if),
      .instr_we    (instr_we),
      .instr_waddr (instr_waddr),
      .instr_wdata (instr_wdata),
      .data_we     (data_we),
      .data_waddr  (data_waddr),
      .data_wdata  (data_wdata),
      .core_rst_n  (core_rst_n),
      .done        (done),
      .err         (err)
   );

   int          n_pass  = 0;
   int          n_total = 0;
   int          missed  = 0;
   logic [7:0]  payload [NBYTES];
   int          ia_q [$];
   logic [31:0] id_q [$];
   int          da_q [$];
   logic [31:0] dd_q [$];

   // Write log: every strobe cycle, recorded just after the edge that set it.
   always @(posedge clk) begin
      #1;
      if (instr_we === 1'b1) begin
         ia_q.push_back(int'(instr_waddr));
         id_q.push_back(instr_wdata);
      end
      if (data_we === 1'b1) begin
         da_q.push_back(int'(data_waddr));
         dd_q.push_back(data_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_if.rx_data  = b;
      rx_if.rx_valid = 1'b1;
      if (rx_if.rx_ready !== 1'b1) missed++;
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'($urandom);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_log();
      ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete();
   endtask

   // Reference: word k of the stream is bytes 4k..4k+3, little-endian.
   function automatic logic [31:0] exp_word(input int k);
      return {payload[4*k+3], payload[4*k+2], payload[4*k+1], payload[4*k]};
   endfunction

   function automatic logic [7:0] payload_xor();
      logic [7:0] x = 8'd0;
      for (int i = 0; i < NBYTES; i++) x ^= payload[i];
      return x;
   endfunction

   task automatic full_load(input bit bad_sum);
      for (int i = 0; i < NBYTES; i++) payload[i] = 8'($urandom);
      for (int i = 0; i < NBYTES; i++) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         send_byte(payload[i]);
      end
`ifdef MEM_LOADER_CHECKSUM_EN
      send_byte(payload_xor() ^ (bad_sum ? 8'h01 : 8'h00));
`else
      if (bad_sum) missed += 1000;
`endif
   endtask

   initial begin
      rst            = 1'b1;
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'h00;

      // Reset state
      idle(2);
      check("rst_instr_we", instr_we, 0);
      check("rst_data_we", data_we, 0);
      check("rst_core_rst_n", core_rst_n, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      idle(1);
      check("rst_rx_ready", rx_if.rx_ready, 1);

      // First word latency and one-cycle strobe
      clear_log();
      send_byte(8'h13); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      check("w0_instr_we", instr_we, 1);
      check("w0_waddr", instr_waddr, 0);
      check("w0_wdata", instr_wdata, 32'h0000_0013);
      check("w0_data_we", data_we, 0);
      idle(1);
      check("w0_strobe_drop", instr_we, 0);

      // Full random load with bubbles
      rst = 1'b1; idle(2); rst = 1'b0;
      clear_log();
      missed = 0;
      full_load(1'b0);
      check("load_rx_ready_low", rx_if.rx_ready, 0);
      check("load_core_rst_n_e0", core_rst_n, 0);
      check("load_done_e0", done, 0);
      idle(1);
      check("load_core_rst_n_e1", core_rst_n, 0);
      idle(1);
      check("load_core_rst_n_e2", core_rst_n, 1);
      check("load_done_e2", done, 1);
      check("load_err", err, 0);
      check("load_no_missed", missed, 0);
      check("load_instr_count", ia_q.size(), DEPTH);
      check("load_data_count", da_q.size(), DEPTH);
      for (int k = 0; k < DEPTH; k++) begin
         check($sformatf("instr_addr[%0d]", k), ia_q[k], k);
         check($sformatf("instr_data[%0d]", k), id_q[k], exp_word(k));
         check($sformatf("data_addr[%0d]", k), da_q[k], k);
         check($sformatf("data_data[%0d]", k), dd_q[k], exp_word(DEPTH + k));
      end

      // RUN is terminal: offered bytes are refused and nothing is written
      missed = 0;
      for (int i = 0; i < 4; i++) send_byte(8'($urandom));
      idle(1);
      check("run_refused", missed, 4);
      check("run_no_instr_write", ia_q.size(), DEPTH);
      check("run_no_data_write", da_q.size(), DEPTH);
      check("run_done_held", done, 1);

      // Reset in RUN drops core_rst_n and done on the same edge
      rst = 1'b1; idle(1);
      check("run_rst_core_rst_n", core_rst_n, 0);
      check("run_rst_done", done, 0);
      rst = 1'b0; idle(1);

      // Reset mid-load restarts at instruction address 0
      clear_log();
      for (int i = 0; i < 10; i++) send_byte(8'($urandom));
      check("mid_words_before_rst", ia_q.size(), 2);
      rst = 1'b1; idle(1); rst = 1'b0;
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      check("mid_instr_we", instr_we, 1);
      check("mid_waddr", instr_waddr, 0);
      check("mid_wdata", instr_wdata, 32'hDDCC_BBAA);

`ifdef MEM_LOADER_CHECKSUM_EN
      // Bad checksum ends in ERROR
      rst = 1'b1; idle(2); rst = 1'b0;
      full_load(1'b1);
      check("bad_err", err, 1);
      check("bad_rx_ready", rx_if.rx_ready, 0);
      check("bad_core_rst_n", core_rst_n, 0);
      idle(3);
      check("bad_core_rst_n_held", core_rst_n, 0);
      check("bad_done", done, 0);
      check("bad_err_held", err, 1);
`else
      check("err_tied_low", err, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
